// File: rtl/game_flow_ctrl.sv
// Brick-breaker game-flow sequencer: serve/play/clear/end states, lives and stage tracking, flow pulses.
// Optional pause support is enabled by defining GAME_FLOW_CTRL_PAUSE_EN.
module game_flow_ctrl #(
   parameter int NUM_LIVES     = 3,
   parameter int LIFE_W        = 3,
   parameter int NUM_STAGES    = 4,
   parameter int STAGE_W       = 2,
   parameter int TIMER_W       = 26,
   parameter int SERVE_TIMEOUT = 0,
   parameter int CLEAR_DELAY   = 25_000_000
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_shoot,
   input  logic               i_pause,
   input  logic               i_life_loss,
   input  logic               i_stage_clear,
   output logic [2:0]         o_state,
   output logic [LIFE_W-1:0]  o_lives,
   output logic [STAGE_W-1:0] o_stage,
   output logic               o_platform_grab,
   output logic               o_serve,
   output logic               o_shoot_fwd,
   output logic               o_startgame,
   output logic               o_endgame,
   output logic               o_win
);

   typedef enum logic [2:0] {
      S_START = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_PAUSE = 3'd3,
      S_CLEAR = 3'd4,
      S_OVER  = 3'd5,
      S_WIN   = 3'd6
   } state_e;

   localparam logic [LIFE_W-1:0]  LIVES_INIT = LIFE_W'(NUM_LIVES);
   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
   localparam logic [TIMER_W-1:0] SERVE_LAST = TIMER_W'(SERVE_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] CLEAR_LAST = TIMER_W'(CLEAR_DELAY - 1);
   localparam logic               AUTO_SERVE = (SERVE_TIMEOUT != 0);

   state_e               state_q, state_d;
   logic [LIFE_W-1:0]    lives_q, lives_d;
   logic [STAGE_W-1:0]   stage_q, stage_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 shoot_q;
   logic                 shoot_rise;
   logic                 pause_rise;
   logic                 grab_q, grab_d;
   logic                 serve_q, serve_d;
   logic                 start_q, start_d;
   logic                 end_q, end_d;
   logic                 win_q, win_d;

   assign shoot_rise = i_shoot & ~shoot_q;

`ifdef GAME_FLOW_CTRL_PAUSE_EN
   logic pause_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) pause_q <= 1'b0;
      else       pause_q <= i_pause;
   end

   assign pause_rise = i_pause & ~pause_q;
`else
   logic unused_pause;

   assign unused_pause = i_pause;
   assign pause_rise   = 1'b0;
`endif

   // State register: FSM state, counters, edge detector and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_START;
         lives_q <= '0;
         stage_q <= '0;
         timer_q <= '0;
         shoot_q <= 1'b0;
         grab_q  <= 1'b0;
         serve_q <= 1'b0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         stage_q <= stage_d;
         timer_q <= timer_d;
         shoot_q <= i_shoot;
         grab_q  <= grab_d;
         serve_q <= serve_d;
         start_q <= start_d;
         end_q   <= end_d;
         win_q   <= win_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      stage_d = stage_q;
      case (state_q)
         S_START: begin
            if (shoot_rise) begin
               state_d = S_SERVE;
               lives_d = LIVES_INIT;
               stage_d = '0;
            end
         end
         S_SERVE: begin
            if (shoot_rise || (AUTO_SERVE && timer_q == SERVE_LAST)) state_d = S_PLAY;
         end
         S_PLAY: begin
            // Life loss outranks a same-cycle stage clear, which is dropped.
            if (i_life_loss) begin
               lives_d = (lives_q != '0) ? lives_q - LIFE_W'(1) : '0;
               state_d = (lives_q <= LIFE_W'(1)) ? S_OVER : S_SERVE;
            end else if (i_stage_clear) begin
               if (stage_q >= LAST_STAGE) begin
                  state_d = S_WIN;
               end else begin
                  stage_d = stage_q + STAGE_W'(1);
                  state_d = S_CLEAR;
               end
            end else if (pause_rise) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (pause_rise) state_d = S_PLAY;
         end
         S_CLEAR: begin
            if (timer_q == CLEAR_LAST) state_d = S_SERVE;
         end
         S_OVER, S_WIN: begin
            if (shoot_rise) state_d = S_START;
         end
         default: state_d = S_START;
      endcase

      // Timer restarts on every state change and only runs where it is consumed.
      if (state_d != state_q || (state_q != S_SERVE && state_q != S_CLEAR)) timer_d = '0;
      else if (timer_q == '1)                                                timer_d = timer_q;
      else                                                                   timer_d = timer_q + TIMER_W'(1);
   end

   always_comb begin
      grab_d  = (state_d == S_SERVE);
      serve_d = (state_q == S_SERVE) && (state_d == S_PLAY);
      start_d = (state_q == S_START) && (state_d == S_SERVE);
      end_d   = (state_q == S_PLAY) && (state_d == S_OVER || state_d == S_WIN);
      win_d   = (state_q == S_PLAY) && (state_d == S_WIN);
   end

   assign o_state         = state_q;
   assign o_lives         = lives_q;
   assign o_stage         = stage_q;
   assign o_platform_grab = grab_q;
   assign o_serve         = serve_q;
   assign o_startgame     = start_q;
   assign o_endgame       = end_q;
   assign o_win           = win_q;
   assign o_shoot_fwd     = i_shoot & (state_q == S_SERVE || state_q == S_PLAY);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl (2 stages, 5-cycle clear, 10-cycle auto-serve).
module tb_game_flow_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       shoot = 1'b0;
   logic       pause = 1'b0;
   logic       life_loss = 1'b0;
   logic       stage_clear = 1'b0;
   logic [2:0] state;
   logic [2:0] lives;
   logic [1:0] stage;
   logic       grab, serve, fwd, startgame, endgame, win;

   int unsigned checks = 0;
   int unsigned failures = 0;

   game_flow_ctrl #(
      .NUM_LIVES    (3),
      .LIFE_W       (3),
      .NUM_STAGES   (2),
      .STAGE_W      (2),
      .TIMER_W      (26),
      .SERVE_TIMEOUT(10),
      .CLEAR_DELAY  (5)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_shoot        (shoot),
      .i_pause        (pause),
      .i_life_loss    (life_loss),
      .i_stage_clear  (stage_clear),
      .o_state        (state),
      .o_lives        (lives),
      .o_stage        (stage),
      .o_platform_grab(grab),
      .o_serve        (serve),
      .o_shoot_fwd    (fwd),
      .o_startgame    (startgame),
      .o_endgame      (endgame),
      .o_win          (win)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Guarantees a fresh rising edge; outputs are sampled after the edge that sees it.
   task automatic press();
      shoot = 1'b0;
      step(1);
      shoot = 1'b1;
      step(1);
      shoot = 1'b0;
   endtask

   task automatic press_pause();
      pause = 1'b0;
      step(1);
      pause = 1'b1;
      step(1);
      pause = 1'b0;
   endtask

   task automatic lose();
      life_loss = 1'b1;
      step(1);
      life_loss = 1'b0;
   endtask

   task automatic clear_stage();
      stage_clear = 1'b1;
      step(1);
      stage_clear = 1'b0;
   endtask

   initial begin
      step(2);
      check("rst_state", state, 0);
      check("rst_lives", lives, 0);
      check("rst_stage", stage, 0);
      check("rst_grab", grab, 0);
      check("rst_serve", serve, 0);
      rst = 1'b0;
      step(1);
      check("idle_state", state, 0);
      shoot = 1'b1;
      #1;
      check("fwd_start", fwd, 0);
      step(1);
      check("start_pulse", startgame, 1);
      check("start_state", state, 1);
      check("start_lives", lives, 3);
      check("start_stage", stage, 0);
      check("start_grab", grab, 1);
      check("fwd_serve", fwd, 1);
      step(1);
      check("held_state", state, 1);
      check("start_once", startgame, 0);
      press();
      check("serve_pulse", serve, 1);
      check("serve_state", state, 2);
      check("play_grab", grab, 0);
      step(1);
      check("serve_once", serve, 0);

      lose();
      check("loss1_lives", lives, 2);
      check("loss1_state", state, 1);
      check("loss1_grab", grab, 1);
      step(9);
      check("auto_wait_state", state, 1);
      check("auto_wait_serve", serve, 0);
      step(1);
      check("auto_serve", serve, 1);
      check("auto_state", state, 2);

      lose();
      check("loss2_lives", lives, 1);
      press();
      check("loss2_play", state, 2);
      lose();
      check("over_state", state, 5);
      check("over_end", endgame, 1);
      check("over_win", win, 0);
      check("over_lives", lives, 0);
      step(1);
      check("over_end_once", endgame, 0);
      check("over_hold", lives, 0);
      press();
      check("restart_state", state, 0);
      check("restart_nopulse", startgame, 0);

      press();
      check("g2_lives", lives, 3);
      press();
      check("g2_play", state, 2);
      life_loss = 1'b1;
      stage_clear = 1'b1;
      step(1);
      life_loss = 1'b0;
      stage_clear = 1'b0;
      check("both_lives", lives, 2);
      check("both_stage", stage, 0);
      check("both_state", state, 1);
      press();
      clear_stage();
      check("clr_state", state, 4);
      check("clr_stage", stage, 1);
      check("clr_noend", endgame, 0);
      step(4);
      check("clr_wait", state, 4);
      step(1);
      check("clr_done", state, 1);
      check("clr_grab", grab, 1);
      press();
      check("clr_serve", serve, 1);
      clear_stage();
      check("win_state", state, 6);
      check("win_pulse", win, 1);
      check("win_end", endgame, 1);
      check("win_stage", stage, 1);
      step(1);
      check("win_once", win, 0);
      check("win_end_once", endgame, 0);
      press();
      check("win_restart", state, 0);

      press();
      press();
      check("g3_play", state, 2);
      shoot = 1'b1;
      #1;
      check("fwd_play", fwd, 1);
      shoot = 1'b0;
      press_pause();
`ifdef GAME_FLOW_CTRL_PAUSE_EN
      check("pause_state", state, 3);
      lose();
      check("pause_lives", lives, 3);
      check("pause_hold", state, 3);
      press_pause();
      check("resume_state", state, 2);
`else
      check("nopause_state", state, 2);
      step(3);
      check("nopause_hold", state, 2);
`endif
      clear_stage();
      check("g3_clear", state, 4);
      step(2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      check("midrst_state", state, 0);
      check("midrst_lives", lives, 0);
      check("midrst_stage", stage, 0);
      check("midrst_grab", grab, 0);
      check("midrst_end", endgame, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
